// File: rtl/rtsnoc_wishbone_fifo_proxy.sv
// Wishbone slave bridging a CPU bus to one RTSNoC router local port through TX/RX packet FIFOs.
// Define RTSNOC_PROXY_STATS_EN to add TX/RX/stall counters at 0x1C-0x24.
module rtsnoc_wishbone_fifo_proxy #(
    parameter int unsigned NOC_X          = 0,
    parameter int unsigned NOC_Y          = 0,
    parameter int unsigned NOC_LOCAL_ADR  = 0,
    parameter int unsigned SOC_SIZE_X     = 1,
    parameter int unsigned SOC_SIZE_Y     = 1,
    parameter int unsigned NOC_DATA_WIDTH = 56,
    parameter int unsigned TX_DEPTH       = 4,
    parameter int unsigned RX_DEPTH       = 4,
    parameter int unsigned WB_ADDR_WIDTH  = 8,
    localparam int unsigned HDR = 2 * (SOC_SIZE_X + SOC_SIZE_Y) + 6,
    localparam int unsigned BUS = NOC_DATA_WIDTH + HDR
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    input  logic                     wb_we_i,
    input  logic [WB_ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [3:0]               wb_sel_i,
    input  logic [31:0]              wb_dat_i,
    output logic [31:0]              wb_dat_o,
    output logic                     wb_ack_o,
    output logic                     noc_int_o,
    output logic [BUS-1:0]           noc_din_o,
    output logic                     noc_wr_o,
    output logic                     noc_rd_o,
    input  logic [BUS-1:0]           noc_dout_i,
    input  logic                     noc_wait_i,
    input  logic                     noc_nd_i
);
    localparam int unsigned SX     = SOC_SIZE_X;
    localparam int unsigned SY     = SOC_SIZE_Y;
    localparam int unsigned DW     = NOC_DATA_WIDTH;
    localparam int unsigned WORDS  = (DW + 31) / 32;
    localparam int unsigned PADW   = WORDS * 32;
    localparam int unsigned TXAW   = $clog2(TX_DEPTH);
    localparam int unsigned RXAW   = $clog2(RX_DEPTH);
    localparam int unsigned TXCW   = TXAW + 1;
    localparam int unsigned RXCW   = RXAW + 1;
    // Header field LSB positions; packet is {Xo,Yo,Lo,Xd,Yd,Ld,data} MSB first
    localparam int unsigned LD_LSB = DW;
    localparam int unsigned YD_LSB = LD_LSB + 3;
    localparam int unsigned XD_LSB = YD_LSB + SY;
    localparam int unsigned LO_LSB = XD_LSB + SX;
    localparam int unsigned YO_LSB = LO_LSB + 3;
    localparam int unsigned XO_LSB = YO_LSB + SY;

    typedef enum logic       {TX_IDLE, TX_SEND} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_ACK, RX_GAP} rx_state_e;

    tx_state_e       tx_state_q, tx_state_d;
    rx_state_e       rx_state_q, rx_state_d;

    logic [BUS-1:0]  tx_mem [TX_DEPTH];
    logic [BUS-1:0]  rx_mem [RX_DEPTH];
    logic [TXAW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [RXAW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [TXCW-1:0] tx_cnt_q, tx_cnt_d;
    logic [RXCW-1:0] rx_cnt_q, rx_cnt_d;

    logic            ack_q, ack_d;
    logic [31:0]     dat_q, dat_d;
    logic            int_q, int_d;
    logic [BUS-1:0]  din_q, din_d;
    logic            wr_q, wr_d;
    logic            rd_q, rd_d;
    logic            irq_en_q, irq_en_d;
    logic [2:0]      hdr_ld_q, hdr_ld_d;
    logic [SX-1:0]   hdr_xd_q, hdr_xd_d;
    logic [SY-1:0]   hdr_yd_q, hdr_yd_d;
    logic [DW-1:0]   tx_data_q, tx_data_d;

    logic [31:0]     adr32;
    logic [29:0]     wa;
    logic            wr_acc, ctrl_wr;
    logic            tx_full, tx_empty, rx_full, rx_empty;
    logic            tx_push, tx_pop, rx_push, rx_pop;
    logic [BUS-1:0]  tx_head, rx_head, tx_entry;
    logic [PADW-1:0] tx_pad, rx_pad, tx_pad_w;
    logic [31:0]     rdata;
    logic            unused_ok;

    assign adr32     = 32'(wb_adr_i);
    assign wa        = adr32[31:2];
    assign unused_ok = ^{wb_sel_i, adr32[1:0]};

    assign ack_d   = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr_acc  = ack_d & wb_we_i;
    assign ctrl_wr = wr_acc && (wa == 30'd3);

    assign tx_full  = (tx_cnt_q == TXCW'(TX_DEPTH));
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == RXCW'(RX_DEPTH));
    assign rx_empty = (rx_cnt_q == '0);

    assign tx_head = tx_mem[tx_rp_q];
    assign rx_head = rx_mem[rx_rp_q];

    assign tx_push = ctrl_wr & wb_dat_i[0] & ~tx_full;
    assign rx_pop  = ctrl_wr & wb_dat_i[1] & ~rx_empty;
    assign tx_pop  = (tx_state_q == TX_IDLE) & ~tx_empty & ~noc_wait_i;
    assign rx_push = (rx_state_q == RX_IDLE) & noc_nd_i & ~rx_full;

    assign tx_entry = {SX'(NOC_X), SY'(NOC_Y), 3'(NOC_LOCAL_ADR),
                       hdr_xd_q, hdr_yd_q, hdr_ld_q, tx_data_q};
    assign tx_pad   = PADW'(tx_data_q);
    assign rx_pad   = rx_empty ? '0 : PADW'(rx_head[DW-1:0]);

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_comb begin
        tx_wp_d  = tx_wp_q + TXAW'(tx_push);
        tx_rp_d  = tx_rp_q + TXAW'(tx_pop);
        tx_cnt_d = tx_cnt_q + TXCW'(tx_push) - TXCW'(tx_pop);
        rx_wp_d  = rx_wp_q + RXAW'(rx_push);
        rx_rp_d  = rx_rp_q + RXAW'(rx_pop);
        rx_cnt_d = rx_cnt_q + RXCW'(rx_push) - RXCW'(rx_pop);
        int_d    = irq_en_q & ~rx_empty;
    end

    // Register writes
    always_comb begin
        irq_en_d = irq_en_q;
        hdr_ld_d = hdr_ld_q;
        hdr_xd_d = hdr_xd_q;
        hdr_yd_d = hdr_yd_q;
        tx_pad_w = tx_pad;
        if (wr_acc) begin
            case (wa)
                30'd3: irq_en_d = wb_dat_i[8];
                30'd4: begin
                    hdr_ld_d = wb_dat_i[2:0];
                    hdr_xd_d = wb_dat_i[8 +: SX];
                    hdr_yd_d = wb_dat_i[16 +: SY];
                end
                default: ;
            endcase
            for (int unsigned i = 0; i < WORDS; i++) begin
                if (wa == 30'(16 + i)) tx_pad_w[32*i +: 32] = wb_dat_i;
            end
        end
        tx_data_d = tx_pad_w[DW-1:0];
    end

`ifdef RTSNOC_PROXY_STATS_EN
    logic [31:0] stat_tx_q, stat_tx_d, stat_rx_q, stat_rx_d, stat_stall_q, stat_stall_d;

    always_comb begin
        stat_tx_d    = stat_tx_q + 32'(wr_q);
        stat_rx_d    = stat_rx_q + 32'(rd_q);
        stat_stall_d = stat_stall_q + 32'((~tx_empty & noc_wait_i) | (noc_nd_i & rx_full));
        if (wr_acc && (wa == 30'd7)) begin
            stat_tx_d    = '0;
            stat_rx_d    = '0;
            stat_stall_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stat_tx_q    <= '0;
            stat_rx_q    <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_tx_q    <= stat_tx_d;
            stat_rx_q    <= stat_rx_d;
            stat_stall_q <= stat_stall_d;
        end
    end
`endif

    // Read mux; unmapped offsets return 0
    always_comb begin
        rdata = '0;
        case (wa)
            30'd0: begin
                rdata[2:0]   = 3'(NOC_LOCAL_ADR);
                rdata[11:8]  = 4'(NOC_X);
                rdata[19:16] = 4'(NOC_Y);
                rdata[23:20] = 4'(SOC_SIZE_X);
                rdata[27:24] = 4'(SOC_SIZE_Y);
            end
            30'd1: rdata = 32'(NOC_DATA_WIDTH);
            30'd2: begin
                rdata[0]     = tx_full;
                rdata[1]     = tx_empty;
                rdata[2]     = rx_empty;
                rdata[3]     = rx_full;
                rdata[12:8]  = 5'(tx_cnt_q);
                rdata[20:16] = 5'(rx_cnt_q);
            end
            30'd3: rdata[8] = irq_en_q;
            30'd4: begin
                rdata[2:0]     = hdr_ld_q;
                rdata[8 +: SX] = hdr_xd_q;
                rdata[16 +: SY] = hdr_yd_q;
            end
            30'd5: if (!rx_empty) begin
                rdata[2:0]      = rx_head[LD_LSB +: 3];
                rdata[8 +: SX]  = rx_head[XD_LSB +: SX];
                rdata[16 +: SY] = rx_head[YD_LSB +: SY];
            end
            30'd6: if (!rx_empty) begin
                rdata[2:0]      = rx_head[LO_LSB +: 3];
                rdata[8 +: SX]  = rx_head[XO_LSB +: SX];
                rdata[16 +: SY] = rx_head[YO_LSB +: SY];
            end
`ifdef RTSNOC_PROXY_STATS_EN
            30'd7: rdata = stat_tx_q;
            30'd8: rdata = stat_rx_q;
            30'd9: rdata = stat_stall_q;
`endif
            default: ;
        endcase
        for (int unsigned i = 0; i < WORDS; i++) begin
            if (wa == 30'(16 + i)) rdata = tx_pad[32*i +: 32];
            if (wa == 30'(24 + i)) rdata = rx_pad[32*i +: 32];
        end
        dat_d = (ack_d & ~wb_we_i) ? rdata : '0;
    end

    // TX engine: one wr pulse per packet, din holds until the next send
    always_comb begin
        tx_state_d = tx_state_q;
        wr_d       = 1'b0;
        din_d      = din_q;
        case (tx_state_q)
            TX_IDLE: if (tx_pop) begin
                tx_state_d = TX_SEND;
                wr_d       = 1'b1;
                din_d      = tx_head;
            end
            TX_SEND: tx_state_d = TX_IDLE;
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // RX engine: ack one flit, then a gap cycle while the router retires it
    always_comb begin
        rx_state_d = rx_state_q;
        rd_d       = 1'b0;
        case (rx_state_q)
            RX_IDLE: if (rx_push) begin
                rx_state_d = RX_ACK;
                rd_d       = 1'b1;
            end
            RX_ACK:  rx_state_d = RX_GAP;
            RX_GAP:  rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wp_q] <= tx_entry;
        if (rx_push) rx_mem[rx_wp_q] <= noc_dout_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tx_state_q <= TX_IDLE;
            rx_state_q <= RX_IDLE;
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            tx_cnt_q   <= '0;
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            rx_cnt_q   <= '0;
            ack_q      <= 1'b0;
            dat_q      <= '0;
            int_q      <= 1'b0;
            din_q      <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            irq_en_q   <= 1'b0;
            hdr_ld_q   <= '0;
            hdr_xd_q   <= '0;
            hdr_yd_q   <= '0;
            tx_data_q  <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            rx_state_q <= rx_state_d;
            tx_wp_q    <= tx_wp_d;
            tx_rp_q    <= tx_rp_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_wp_q    <= rx_wp_d;
            rx_rp_q    <= rx_rp_d;
            rx_cnt_q   <= rx_cnt_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            int_q      <= int_d;
            din_q      <= din_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            irq_en_q   <= irq_en_d;
            hdr_ld_q   <= hdr_ld_d;
            hdr_xd_q   <= hdr_xd_d;
            hdr_yd_q   <= hdr_yd_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign wb_ack_o  = ack_q;
    assign wb_dat_o  = dat_q;
    assign noc_int_o = int_q;
    assign noc_din_o = din_q;
    assign noc_wr_o  = wr_q;
    assign noc_rd_o  = rd_q;

endmodule

// File: tb/tb_rtsnoc_wishbone_fifo_proxy.sv
// Scoreboard bench for rtsnoc_wishbone_fifo_proxy: queued expectations for WB reads and
// router packets, with a queue-based router model feeding the RX side.
module tb_rtsnoc_wishbone_fifo_proxy;
    localparam int unsigned DW  = 56;
    localparam int unsigned BUS = 66;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           wb_cyc, wb_stb, wb_we, wb_ack;
    logic [7:0]     wb_adr;
    logic [3:0]     wb_sel;
    logic [31:0]    wb_dat_w, wb_dat_r;
    logic           noc_int, noc_wr, noc_rd, noc_wait, noc_nd;
    logic [BUS-1:0] noc_din, noc_dout;

    rtsnoc_wishbone_fifo_proxy #(
        .NOC_X(1), .NOC_Y(0), .NOC_LOCAL_ADR(2), .SOC_SIZE_X(1), .SOC_SIZE_Y(1),
        .NOC_DATA_WIDTH(DW), .TX_DEPTH(4), .RX_DEPTH(4), .WB_ADDR_WIDTH(8)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we), .wb_adr_i(wb_adr),
        .wb_sel_i(wb_sel), .wb_dat_i(wb_dat_w), .wb_dat_o(wb_dat_r), .wb_ack_o(wb_ack),
        .noc_int_o(noc_int), .noc_din_o(noc_din), .noc_wr_o(noc_wr), .noc_rd_o(noc_rd),
        .noc_dout_i(noc_dout), .noc_wait_i(noc_wait), .noc_nd_i(noc_nd)
    );

    always #5 clk = ~clk;

    int             total = 0;
    int             bad = 0;
    int             wr_pulses = 0;
    int             rd_pulses = 0;
    int             tx_model_cnt = 0;
    logic           irq_en = 1'b0;
    logic [BUS-1:0] tx_exp[$];
    logic [31:0]    rd_exp[$];
    string          rd_name[$];
    logic [BUS-1:0] router_q[$];
    logic [BUS-1:0] rx_model[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [BUS-1:0] mk_flit(input logic xo, input logic yo, input logic [2:0] lo,
                                               input logic xd, input logic yd, input logic [2:0] ld,
                                               input logic [DW-1:0] data);
        return {xo, yo, lo, xd, yd, ld, data};
    endfunction

    function automatic logic [31:0] hdr_word(input logic x, input logic y, input logic [2:0] l);
        return {15'b0, y, 7'b0, x, 5'b0, l};
    endfunction

    task automatic wb_xfer(input logic we, input logic [7:0] adr, input logic [31:0] dat);
        int n;
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_w = dat;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!wb_ack && n < 10);
        chk("wb_ack", 128'(wb_ack), 128'(1));
        @(negedge clk); #1;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wb_read(input logic [7:0] adr, input logic [31:0] exp, input string name);
        rd_exp.push_back(exp);
        rd_name.push_back(name);
        wb_xfer(1'b0, adr, 32'h0);
    endtask

    function automatic logic [31:0] ctrl_word(input logic push, input logic pop);
        return {23'b0, irq_en, 6'b0, pop, push};
    endfunction

    // Program header and data, then push; the model accepts it only when TX has room
    task automatic tx_send(input logic xd, input logic yd, input logic [2:0] ld,
                           input logic [DW-1:0] data, input logic [31:0] junk);
        wb_xfer(1'b1, 8'h10, (junk & 32'hFFFE_FEF8) | hdr_word(xd, yd, ld));
        wb_xfer(1'b1, 8'h40, data[31:0]);
        wb_xfer(1'b1, 8'h44, {junk[7:0], data[55:32]});
        if (tx_model_cnt < 4) begin
            tx_exp.push_back(mk_flit(1'b1, 1'b0, 3'd2, xd, yd, ld, data));
            tx_model_cnt++;
        end
        wb_xfer(1'b1, 8'h0C, ctrl_word(1'b1, 1'b0));
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor and router model
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (wb_ack && !wb_we) begin
                if (rd_exp.size() == 0) chk("rd_unexpected", 128'(wb_ack), 128'(0));
                else chk(rd_name.pop_front(), 128'(wb_dat_r), 128'(rd_exp.pop_front()));
            end
            if (noc_wr) begin
                wr_pulses++;
                tx_model_cnt--;
                if (tx_exp.size() == 0) chk("tx_unexpected", 128'(noc_wr), 128'(0));
                else chk("tx_pkt", 128'(noc_din), 128'(tx_exp.pop_front()));
            end
            if (noc_rd) begin
                rd_pulses++;
                if (router_q.size() > 0) rx_model.push_back(router_q.pop_front());
            end
        end
        noc_nd   = (router_q.size() > 0);
        noc_dout = (router_q.size() > 0) ? router_q[0] : '0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, r0, t_prev;
        logic [DW-1:0] d;
        rst_n = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_adr = '0;
        wb_sel = 4'hF; wb_dat_w = '0; noc_wait = 1'b0; noc_nd = 1'b0; noc_dout = '0;
        cycles(3);
        rst_n = 1'b1;

        // Reset state and identification
        chk("rst_wr", 128'(noc_wr), 0);
        chk("rst_rd", 128'(noc_rd), 0);
        chk("rst_int", 128'(noc_int), 0);
        wb_read(8'h08, 32'h0000_0006, "rst_status");
        wb_read(8'h00, 32'h0110_0102, "info");
        wb_read(8'h04, 32'd56, "width");
        wb_read(8'h0C, 32'h0, "rst_ctrl");
        wb_read(8'h10, 32'h0, "rst_tx_hdr");
        wb_read(8'h40, 32'h0, "rst_tx_data0");
        wb_read(8'h14, 32'h0, "rst_rx_dst");
        wb_read(8'h1C, 32'h0, "rst_stat0");
        wb_xfer(1'b1, 8'h34, 32'hFFFF_FFFF);
        wb_read(8'h34, 32'h0, "unmapped");
        wb_read(8'h48, 32'h0, "tx_data2_absent");

        // Single TX packet with fixed fields
        wb_xfer(1'b1, 8'h10, 32'h0001_0103);
        wb_xfer(1'b1, 8'h40, 32'hDEAD_BEEF);
        wb_xfer(1'b1, 8'h44, 32'hFFAB_CDEF);
        wb_read(8'h10, 32'h0001_0103, "tx_hdr_rb");
        wb_read(8'h44, 32'h00AB_CDEF, "tx_data1_mask");
        w0 = wr_pulses;
        tx_exp.push_back(mk_flit(1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 3'd3, 56'hABCDEF_DEADBEEF));
        tx_model_cnt++;
        wb_xfer(1'b1, 8'h0C, ctrl_word(1'b1, 1'b0));
        cycles(10);
        chk("tx_one_pulse", 128'(wr_pulses - w0), 128'(1));
        chk("din_hold", 128'(noc_din), 128'(mk_flit(1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 3'd3, 56'hABCDEF_DEADBEEF)));

        // TX stall and overflow, then drain with back-to-back spacing
        noc_wait = 1'b1;
        w0 = wr_pulses;
        for (int k = 0; k < 5; k++) begin
            d = {24'($urandom), $urandom};
            tx_send(1'($urandom), 1'($urandom), 3'($urandom), d, $urandom);
        end
        cycles(4);
        chk("tx_stall_no_wr", 128'(wr_pulses - w0), 128'(0));
        wb_read(8'h08, 32'h0000_0405, "tx_full_status");
        noc_wait = 1'b0;
        t_prev = -1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (noc_wr) begin
                if (t_prev >= 0) chk("tx_spacing", 128'(c - t_prev), 128'(2));
                t_prev = c;
            end
        end
        chk("tx_drain_count", 128'(wr_pulses - w0), 128'(4));
        chk("tx_exp_left", 128'(tx_exp.size()), 128'(0));

        // Single RX flit, interrupt raise and clear
        r0 = rd_pulses;
        router_q.push_back(mk_flit(1'b1, 1'b1, 3'd5, 1'b0, 1'b1, 3'd2, 56'h1234));
        cycles(12);
        chk("rx_one_pulse", 128'(rd_pulses - r0), 128'(1));
        chk("router_drained", 128'(router_q.size()), 128'(0));
        chk("int_disabled", 128'(noc_int), 128'(0));
        wb_read(8'h08, 32'h0001_0002, "rx_status");
        wb_read(8'h60, rx_model[0][31:0], "rx_data0");
        wb_read(8'h64, {8'h0, rx_model[0][55:32]}, "rx_data1");
        wb_read(8'h14, hdr_word(1'b0, 1'b1, 3'd2), "rx_dst");
        wb_read(8'h18, hdr_word(1'b1, 1'b1, 3'd5), "rx_orig");
        wb_read(8'h7C, 32'h0, "rx_data7_absent");
        irq_en = 1'b1;
        wb_xfer(1'b1, 8'h0C, ctrl_word(1'b0, 1'b0));
        wb_read(8'h0C, 32'h0000_0100, "ctrl_rb");
        chk("int_set", 128'(noc_int), 128'(1));
        wb_xfer(1'b1, 8'h0C, ctrl_word(1'b0, 1'b1));
        void'(rx_model.pop_front());
        chk("int_latency", 128'(noc_int), 128'(1));
        cycles(1);
        chk("int_clear", 128'(noc_int), 128'(0));
        wb_read(8'h08, 32'h0000_0006, "rx_empty_status");
        wb_xfer(1'b1, 8'h0C, ctrl_word(1'b0, 1'b1));
        wb_read(8'h08, 32'h0000_0006, "pop_empty_ignored");

        // RX backpressure
        r0 = rd_pulses;
        for (int k = 0; k < 6; k++) begin
            d = {24'($urandom), $urandom};
            router_q.push_back(mk_flit(1'($urandom), 1'($urandom), 3'($urandom),
                                       1'($urandom), 1'($urandom), 3'($urandom), d));
        end
        cycles(40);
        chk("rx_fill_pulses", 128'(rd_pulses - r0), 128'(4));
        chk("router_held", 128'(router_q.size()), 128'(2));
        wb_read(8'h08, 32'h0004_000A, "rx_full_status");
        r0 = rd_pulses;
        wb_xfer(1'b1, 8'h0C, ctrl_word(1'b0, 1'b1));
        void'(rx_model.pop_front());
        cycles(20);
        chk("rx_one_more", 128'(rd_pulses - r0), 128'(1));
        chk("router_one_left", 128'(router_q.size()), 128'(1));
        chk("int_pending", 128'(noc_int), 128'(1));
        for (int it = 0; it < 16 && (rx_model.size() > 0 || router_q.size() > 0); it++) begin
            if (rx_model.size() > 0) begin
                wb_read(8'h60, rx_model[0][31:0], "drain_data0");
                wb_read(8'h64, {8'h0, rx_model[0][55:32]}, "drain_data1");
                wb_read(8'h14, hdr_word(rx_model[0][60], rx_model[0][59], rx_model[0][58:56]), "drain_dst");
                wb_xfer(1'b1, 8'h0C, ctrl_word(1'b0, 1'b1));
                void'(rx_model.pop_front());
            end else begin
                cycles(5);
            end
        end
        cycles(3);
        wb_read(8'h08, 32'h0000_0006, "drained_status");
        chk("int_after_drain", 128'(noc_int), 128'(0));

        // Async reset during SEND
        noc_wait = 1'b1;
        tx_send(1'b0, 1'b1, 3'd1, 56'h11, 32'h0);
        tx_send(1'b1, 1'b0, 3'd6, 56'h22, 32'h0);
        noc_wait = 1'b0;
        for (int n = 0; n < 10 && !noc_wr; n++) begin
            @(posedge clk); #1;
        end
        chk("wr_seen", 128'(noc_wr), 128'(1));
        #2 rst_n = 1'b0;
        #1 chk("wr_async_drop", 128'(noc_wr), 128'(0));
        tx_exp.delete();
        tx_model_cnt = 0;
        irq_en = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(4);
        chk("no_wr_after_rst", 128'(noc_wr), 128'(0));
        wb_read(8'h08, 32'h0000_0006, "tx_rst_status");

        // Async reset during ACK
        router_q.push_back(mk_flit(1'b0, 1'b0, 3'd7, 1'b1, 1'b1, 3'd1, 56'h55));
        for (int n = 0; n < 10 && !noc_rd; n++) begin
            @(posedge clk); #1;
        end
        chk("rd_seen", 128'(noc_rd), 128'(1));
        #2 rst_n = 1'b0;
        #1 chk("rd_async_drop", 128'(noc_rd), 128'(0));
        router_q.delete();
        rx_model.delete();
        cycles(2);
        rst_n = 1'b1;
        wb_read(8'h08, 32'h0000_0006, "rx_rst_status");
        wb_read(8'h0C, 32'h0, "rst_irq_en");
        wb_read(8'h1C, 32'h0, "stat_tx_rst");
        wb_read(8'h20, 32'h0, "stat_rx_rst");
        wb_read(8'h24, 32'h0, "stat_stall_rst");
        chk("int_after_rst", 128'(noc_int), 128'(0));
        chk("rd_queue_left", 128'(rd_exp.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
